render_cmd_assembler: RTL and testbench
=======================================

# render_cmd_assembler

Assembles the HPS's byte-wide register writes into 48-bit render commands and hands each completed command to the VGA render queue through a one-entry valid/ready output slot. It sits between the HPS slave write port and the render FIFO's write side, in the `clk50` domain. It also decodes the in-band clear command and reports dropped or malformed commands.

## Interface
- `CMD_BYTES`, 6: bytes per render command; command width is `8*CMD_BYTES`.
- `CLEAR_OPCODE`, 8'hFE: value that, written to address 0, requests a clear.
- `DROP_CNT_W`, 8: width of the saturating drop counter.

Ports:
- `clk50`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  high while the design is in the running state; writes are ignored when low.
- `hps_write`  in  1  HPS write strobe.
- `hps_chipselect`  in  1  HPS chip select; a write is accepted only when both are high.
- `hps_address`  in  3  byte lane; 0 is the MSB byte `[47:40]` through 5 `[7:0]`; 7 is abort; 6 is ignored.
- `hps_writedata`  in  8  byte data.
- `cmd_data`  out  48  committed command to the render FIFO `din`.
- `cmd_valid`  out  1  output slot holds a command.
- `cmd_ready`  in  1  render FIFO can accept this cycle (not full).
- `clear_pulse`  out  1  one-cycle clear request to the FIFOs and loader.
- `drop_count`  out  `DROP_CNT_W`  saturating count of dropped commands.
- `busy`  out  1  staging mask non-zero or `cmd_valid` high.

## Operation
- An accepted write is `hps_write & hps_chipselect & enable`. Writes with `enable` low have no effect and are not counted.
- Staging register: 48 bits plus a 6-bit byte mask.
  - A write to address k (0–5) stores the byte into lane k and sets mask bit k.
  - Rewriting a lane before commit overwrites it (last write wins).
- Clear:
  - Trigger: an accepted write of `CLEAR_OPCODE` to address 0.
  - Effect: the byte is not stored, the mask is cleared, `cmd_valid` is cleared without handshake, and `clear_pulse` is asserted for exactly one cycle.
  - `drop_count` is not changed.
- Abort: a write to address 7 clears the mask. Staging data is don't-care. No count change.
- Commit: triggered by a write to address 5, with the mask evaluated including bit 5.
  - Mask all ones and slot free: load `cmd_data` and set `cmd_valid`. The slot is free when `cmd_valid` is low, or when `cmd_valid & cmd_ready` in the same cycle.
  - Mask all ones and slot occupied and not draining: the command is dropped and `drop_count` increments.
  - Mask incomplete: the command is dropped (malformed) and `drop_count` increments.
  - In all three cases the mask clears.
- Output slot:
  - A transfer occurs when `cmd_valid & cmd_ready`.
  - `cmd_data` is stable while `cmd_valid` is high and not accepted.
  - `cmd_valid` falls after a transfer unless a new commit loads in the same cycle.
- `drop_count` saturates at all-ones and clears only on `reset`.
- Staging and output slot are independent FSMs:
  - Staging: EMPTY (mask==0) → PARTIAL on a lane write; PARTIAL → EMPTY on commit, abort or clear.
  - Slot: EMPTY → FULL on commit; FULL → EMPTY on transfer or clear; FULL → FULL on transfer plus commit in the same cycle.

## Timing
- All outputs are registered.
- Reset values: `cmd_data`=0, `cmd_valid`=0, `clear_pulse`=0, `drop_count`=0, `busy`=0, mask=0.
- Commit latency: an address-5 write at edge N gives `cmd_valid`/`cmd_data` valid after edge N (visible in cycle N+1).
- Clear latency: the clear write at edge N gives `clear_pulse` high in cycle N+1 only.
- Clear has priority over a transfer or commit in the same cycle; `reset` has priority over everything.
- Back-to-back commits:
  - Sustained at one per 6 write cycles with `cmd_ready` held high.
  - A commit in the same cycle as a transfer is accepted (no bubble).
- `reset` asserted mid-assembly discards staging and the slot; no `clear_pulse` is generated.

## Structure
- Package `render_cmd_pkg`: `CMD_BYTES`, `CMD_W`=48, `CLEAR_OPCODE`, `ABORT_ADDR`=3'h7, and a `render_cmd_t` packed struct for the 48-bit command, shared with `vga_display`.
- One sub-module: `render_cmd_slot`, a one-entry valid/ready register with load, flush and `free` outputs.

## Test plan
- Write bytes 11,22,33,44,55,66 to addresses 0–5 with `cmd_ready`=1 → `cmd_data`=48'h112233445566 and `cmd_valid` high one cycle later; `drop_count`=0.
- Hold `cmd_ready`=0, commit two full commands → first is held stable; second is dropped and `drop_count`=1; raise `cmd_ready` → first transfers and `cmd_valid` falls.
- Write addresses 0–3 then 5 (skip 4) → no `cmd_valid`; `drop_count`=1, `busy`=0.
- With a command pending, write 8'hFE to address 0 → `clear_pulse` high exactly one cycle and `cmd_valid`=0. Write 8'hFD to address 0 → stored as data, no clear.
- 300 malformed commits → `drop_count` saturates at 255. `enable`=0 with a full write sequence → no change to any output.
- Transfer and new commit in the same cycle → `cmd_valid` stays high and `cmd_data` updates to the new value. Assert `reset` mid-sequence → all outputs return to zero.

Source files
------------

// File: rtl/render_cmd_pkg.sv
// Shared render command definitions: byte count, opcodes and the
// 48-bit command layout used by the assembler and vga_display.
package render_cmd_pkg;

   localparam int          CMD_BYTES    = 6;
   localparam int          CMD_W        = 8 * CMD_BYTES;
   localparam logic [7:0]  CLEAR_OPCODE = 8'hFE;
   localparam logic [2:0]  ABORT_ADDR   = 3'h7;
   localparam logic [2:0]  COMMIT_ADDR  = 3'(CMD_BYTES - 1);

   // lane[CMD_BYTES-1] is the MSB byte, written at address 0
   typedef struct packed {
      logic [CMD_BYTES-1:0][7:0] lane;
   } render_cmd_t;

   typedef enum logic {
      STG_EMPTY,
      STG_PARTIAL
   } stg_state_t;

   typedef enum logic {
      SLOT_EMPTY,
      SLOT_FULL
   } slot_state_t;

   function automatic logic [2:0] lane_of(input logic [2:0] addr);
      return 3'(CMD_BYTES - 1) - addr;
   endfunction

endpackage

// File: rtl/render_cmd_slot.sv
// One-entry valid/ready output register with load and flush.
// Ports: load/flush/din in, dout/valid out, free and valid_next hints.
module render_cmd_slot
   import render_cmd_pkg::*;
(
   input  logic        clk50,
   input  logic        reset,
   input  logic        load,
   input  logic        flush,
   input  render_cmd_t din,
   input  logic        cmd_ready,
   output render_cmd_t dout,
   output logic        valid,
   output logic        free,
   output logic        valid_next
);

   slot_state_t st;

   assign valid = (st == SLOT_FULL);
   assign free  = !valid || cmd_ready;

   always_comb begin
      valid_next = valid;
      if (flush)
         valid_next = 1'b0;
      else if (load)
         valid_next = 1'b1;
      else if (valid && cmd_ready)
         valid_next = 1'b0;
   end

   always_ff @(posedge clk50) begin
      if (reset) begin
         st   <= SLOT_EMPTY;
         dout <= '0;
      end else begin
         st <= valid_next ? SLOT_FULL : SLOT_EMPTY;
         if (load && !flush)
            dout <= din;
      end
   end

endmodule

// File: rtl/render_cmd_assembler.sv
// Packs HPS byte writes into 48-bit render commands for the render FIFO.
// Ports: HPS write port in, cmd_data/cmd_valid/cmd_ready slot, clear, drops, busy.
module render_cmd_assembler
   import render_cmd_pkg::*;
#(
   parameter int DROP_CNT_W = 8
) (
   input  logic                  clk50,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  hps_write,
   input  logic                  hps_chipselect,
   input  logic [2:0]            hps_address,
   input  logic [7:0]            hps_writedata,
   output logic [CMD_W-1:0]      cmd_data,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic                  clear_pulse,
   output logic [DROP_CNT_W-1:0] drop_count,
   output logic                  busy
);

   logic                 acc;
   logic                 is_clr;
   logic                 is_abort;
   logic                 is_commit;
   logic                 lane_wr;
   logic                 full;
   logic                 slot_free;
   logic                 slot_vnext;
   logic                 load;
   logic                 drop;
   logic [CMD_BYTES-1:0] mask;
   logic [CMD_BYTES-1:0] mask_set;
   logic [CMD_BYTES-1:0] mask_n;
   stg_state_t           stg_n;
   render_cmd_t          stage;
   render_cmd_t          stage_n;
   render_cmd_t          slot_q;

   assign acc      = hps_write && hps_chipselect && enable;
   assign is_clr   = acc && (hps_address == 3'h0)
                   && (hps_writedata == CLEAR_OPCODE);
   assign is_abort = acc && (hps_address == ABORT_ADDR);
   assign is_commit = acc && (hps_address == COMMIT_ADDR);
   assign lane_wr  = acc && !is_clr
                   && (hps_address <= COMMIT_ADDR);

   // Commit sees the byte written in the same cycle
   always_comb begin
      stage_n  = stage;
      mask_set = mask;
      if (lane_wr) begin
         stage_n.lane[lane_of(hps_address)] = hps_writedata;
         mask_set[hps_address] = 1'b1;
      end
   end

   assign full = &mask_set;
   assign load = is_commit && full && slot_free;
   assign drop = is_commit && !(full && slot_free);

   always_comb begin
      mask_n = mask_set;
      if (is_clr || is_abort || is_commit)
         mask_n = '0;
      stg_n = (mask_n != '0) ? STG_PARTIAL : STG_EMPTY;
   end

   render_cmd_slot u_slot (
      .clk50      (clk50),
      .reset      (reset),
      .load       (load),
      .flush      (is_clr),
      .din        (stage_n),
      .cmd_ready  (cmd_ready),
      .dout       (slot_q),
      .valid      (cmd_valid),
      .free       (slot_free),
      .valid_next (slot_vnext)
   );

   assign cmd_data = slot_q;

   always_ff @(posedge clk50) begin
      if (reset) begin
         mask        <= '0;
         stage       <= '0;
         clear_pulse <= 1'b0;
         drop_count  <= '0;
         busy        <= 1'b0;
      end else begin
         mask        <= mask_n;
         stage       <= stage_n;
         clear_pulse <= is_clr;
         busy        <= (stg_n == STG_PARTIAL) || slot_vnext;
         if (drop && (drop_count != '1))
            drop_count <= drop_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_render_cmd_assembler.sv
// Directed bench for render_cmd_assembler: vector table plus
// hand sequences for overlap, saturation and mid-assembly reset.
module tb_render_cmd_assembler;

   logic        clk50 = 1'b0;
   logic        reset;
   logic        enable;
   logic        hps_write;
   logic        hps_chipselect;
   logic [2:0]  hps_address;
   logic [7:0]  hps_writedata;
   logic [47:0] cmd_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        clear_pulse;
   logic [7:0]  drop_count;
   logic        busy;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk50 = ~clk50;

   render_cmd_assembler dut (
      .clk50          (clk50),
      .reset          (reset),
      .enable         (enable),
      .hps_write      (hps_write),
      .hps_chipselect (hps_chipselect),
      .hps_address    (hps_address),
      .hps_writedata  (hps_writedata),
      .cmd_data       (cmd_data),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .clear_pulse    (clear_pulse),
      .drop_count     (drop_count),
      .busy           (busy)
   );

   typedef struct {
      logic        w;
      logic        cs;
      logic        en;
      logic [2:0]  a;
      logic [7:0]  d;
      logic        r;
      logic        ev;
      logic [47:0] ed;
      logic        cd;
      logic        ec;
      logic [7:0]  edc;
      logic        eb;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic w, cs, en,
                      input logic [2:0] a, input logic [7:0] d,
                      input logic r, ev, input logic [47:0] ed,
                      input logic cd, ec, input logic [7:0] edc,
                      input logic eb);
      vec_t v;
      v.w = w; v.cs = cs; v.en = en; v.a = a; v.d = d; v.r = r;
      v.ev = ev; v.ed = ed; v.cd = cd; v.ec = ec; v.edc = edc; v.eb = eb;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [47:0] act,
                      input logic [47:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic w, cs, en, input logic [2:0] a,
                      input logic [7:0] d, input logic r);
      @(negedge clk50);
      hps_write      = w;
      hps_chipselect = cs;
      enable         = en;
      hps_address    = a;
      hps_writedata  = d;
      cmd_ready      = r;
      @(posedge clk50);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d,
                     input logic r);
      cyc(1'b1, 1'b1, 1'b1, a, d, r);
   endtask

   logic [47:0] D1, D2, D3, D4, DA, DB;

   initial begin
      D1 = 48'h112233445566;
      D2 = 48'h010203040506;
      D3 = 48'h212223242526;
      D4 = 48'hFD0203040506;
      DA = 48'hA0A1A2A3A4A5;
      DB = 48'hB0B1B2B3B4B5;

      reset = 1'b1; enable = 1'b1; hps_write = 1'b0;
      hps_chipselect = 1'b0; hps_address = 3'h0;
      hps_writedata = 8'h00; cmd_ready = 1'b0;
      repeat (2) @(posedge clk50);
      #1;
      chk("rst cmd_data", cmd_data, 48'h0);
      chk("rst cmd_valid", 48'(cmd_valid), 48'h0);
      chk("rst clear_pulse", 48'(clear_pulse), 48'h0);
      chk("rst drop_count", 48'(drop_count), 48'h0);
      chk("rst busy", 48'(busy), 48'h0);
      @(negedge clk50);
      reset = 1'b0;

      for (int k = 0; k < 5; k++)
         add(1,1,1,3'(k),8'(8'h11*(k+1)),1, 0,48'h0,1, 0,8'd0,1);
      add(1,1,1,3'd5,8'h66,1, 1,D1,1, 0,8'd0,1);
      add(0,0,1,3'd0,8'h00,1, 0,D1,1, 0,8'd0,0);
      for (int k = 0; k < 5; k++)
         add(1,1,1,3'(k),8'(k+1),0, 0,D1,1, 0,8'd0,1);
      add(1,1,1,3'd5,8'h06,0, 1,D2,1, 0,8'd0,1);
      for (int k = 0; k < 5; k++)
         add(1,1,1,3'(k),8'(8'h0A+k),0, 1,D2,1, 0,8'd0,1);
      add(1,1,1,3'd5,8'h0F,0, 1,D2,1, 0,8'd1,1);
      add(0,0,1,3'd0,8'h00,1, 0,D2,1, 0,8'd1,0);
      for (int k = 0; k < 4; k++)
         add(1,1,1,3'(k),8'h77,1, 0,D2,1, 0,8'd1,1);
      add(1,1,1,3'd5,8'h77,1, 0,D2,1, 0,8'd2,0);
      for (int k = 0; k < 5; k++)
         add(1,1,1,3'(k),8'(8'h21+k),0, 0,D2,1, 0,8'd2,1);
      add(1,1,1,3'd5,8'h26,0, 1,D3,1, 0,8'd2,1);
      add(1,1,1,3'd0,8'hFE,0, 0,D3,0, 1,8'd2,0);
      add(0,0,1,3'd0,8'h00,0, 0,D3,0, 0,8'd2,0);
      add(1,1,1,3'd0,8'hFD,1, 0,D3,0, 0,8'd2,1);
      for (int k = 1; k < 5; k++)
         add(1,1,1,3'(k),8'(k+1),1, 0,D3,0, 0,8'd2,1);
      add(1,1,1,3'd5,8'h06,1, 1,D4,1, 0,8'd2,1);
      add(0,0,1,3'd0,8'h00,1, 0,D4,1, 0,8'd2,0);
      add(1,1,1,3'd0,8'h77,1, 0,D4,1, 0,8'd2,1);
      add(1,1,1,3'd7,8'h00,1, 0,D4,1, 0,8'd2,0);
      add(1,1,1,3'd5,8'h99,1, 0,D4,1, 0,8'd3,0);
      for (int k = 0; k < 6; k++)
         add(1,1,0,3'(k),8'(8'h11*(k+1)),1, 0,D4,1, 0,8'd3,0);
      add(1,0,1,3'd0,8'h12,1, 0,D4,1, 0,8'd3,0);
      add(1,1,1,3'd6,8'h12,1, 0,D4,1, 0,8'd3,0);

      foreach (vq[i]) begin
         cyc(vq[i].w, vq[i].cs, vq[i].en, vq[i].a, vq[i].d, vq[i].r);
         chk($sformatf("v%0d valid", i), 48'(cmd_valid), 48'(vq[i].ev));
         if (vq[i].cd)
            chk($sformatf("v%0d data", i), cmd_data, vq[i].ed);
         chk($sformatf("v%0d clear", i), 48'(clear_pulse), 48'(vq[i].ec));
         chk($sformatf("v%0d drops", i), 48'(drop_count), 48'(vq[i].edc));
         chk($sformatf("v%0d busy", i), 48'(busy), 48'(vq[i].eb));
      end

      for (int k = 0; k < 6; k++)
         wr(3'(k), 8'(8'hA0 + k), 1'b0);
      chk("ovl A valid", 48'(cmd_valid), 48'h1);
      chk("ovl A data", cmd_data, DA);
      for (int k = 0; k < 5; k++)
         wr(3'(k), 8'(8'hB0 + k), 1'b0);
      chk("ovl A held", cmd_data, DA);
      wr(3'd5, 8'hB5, 1'b1);
      chk("ovl B valid", 48'(cmd_valid), 48'h1);
      chk("ovl B data", cmd_data, DB);
      chk("ovl drops", 48'(drop_count), 48'd3);
      cyc(0, 0, 1, 3'd0, 8'h00, 1'b1);
      chk("ovl drain", 48'(cmd_valid), 48'h0);

      for (int k = 0; k < 251; k++)
         wr(3'd5, 8'h00, 1'b1);
      chk("sat 254", 48'(drop_count), 48'd254);
      for (int k = 0; k < 49; k++)
         wr(3'd5, 8'h00, 1'b1);
      chk("sat 255", 48'(drop_count), 48'd255);
      chk("sat valid", 48'(cmd_valid), 48'h0);

      for (int k = 0; k < 6; k++)
         wr(3'(k), 8'(8'hC0 + k), 1'b0);
      wr(3'd0, 8'h01, 1'b0);
      wr(3'd1, 8'h02, 1'b0);
      chk("pre-rst busy", 48'(busy), 48'h1);
      chk("pre-rst valid", 48'(cmd_valid), 48'h1);
      @(negedge clk50);
      reset = 1'b1;
      wr(3'd0, CLEAR_OP(), 1'b0);
      @(negedge clk50);
      reset = 1'b0;
      #1;
      chk("mid-rst data", cmd_data, 48'h0);
      chk("mid-rst valid", 48'(cmd_valid), 48'h0);
      chk("mid-rst clear", 48'(clear_pulse), 48'h0);
      chk("mid-rst drops", 48'(drop_count), 48'h0);
      chk("mid-rst busy", 48'(busy), 48'h0);
      for (int k = 2; k < 6; k++)
         wr(3'(k), 8'h5A, 1'b0);
      chk("post-rst valid", 48'(cmd_valid), 48'h0);
      chk("post-rst drops", 48'(drop_count), 48'd1);
      chk("post-rst clear", 48'(clear_pulse), 48'h0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   function automatic logic [7:0] CLEAR_OP();
      return 8'hFE;
   endfunction

endmodule
